// File: rtl/hvac_sensor_if_if.sv
`default_nettype none
// ============================================================================
// Module      : hvac_sensor_if_if
// Description : Signal bundle between the HVAC sensor front end and its
//               environment. The master side drives the raw temperature sample
//               stream and the raw push-button. The slave side (the front end)
//               returns the clean level requests.
// Ports       : temp_valid  - temp holds a new sample this cycle
//               temp[TW-1:0]- unsigned temperature sample
//               key_raw     - raw, bouncy, asynchronous push-button
//               t_cao       - too-hot request
//               t_thap      - too-cold request
//               keypad      - ventilation request level
// Revision    : 1.0 - initial release
// ============================================================================
interface hvac_sensor_if_if #(
    parameter int TW = 8
) ();
    logic          temp_valid;
    logic [TW-1:0] temp;
    logic          key_raw;
    logic          t_cao;
    logic          t_thap;
    logic          keypad;

    modport master (
        output temp_valid,
        output temp,
        output key_raw,
        input  t_cao,
        input  t_thap,
        input  keypad
    );

    modport slave (
        input  temp_valid,
        input  temp,
        input  key_raw,
        output t_cao,
        output t_thap,
        output keypad
    );
endinterface
`default_nettype wire

// File: rtl/hvac_sensor_if.sv
`default_nettype none
// ============================================================================
// Module      : hvac_sensor_if
// Description : Input-conditioning front end for the HVAC controller.
//               The temperature path qualifies samples against the hot and
//               cold thresholds. It requires CONFIRM consecutive qualifying
//               samples for every state change and applies a hysteresis band
//               on exit. The button path synchronises the raw key with two
//               flops, debounces it over DB_CYCLES clocks and either toggles
//               or follows the keypad request.
// Ports       : clk  - clock
//               rst  - asynchronous reset, active low
//               bus  - hvac_sensor_if_if.slave (temp_valid, temp, key_raw in;
//                      t_cao, t_thap, keypad out, all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module hvac_sensor_if #(
    parameter int TW        = 8,
    parameter int T_HI      = 30,
    parameter int T_LO      = 18,
    parameter int HYST      = 2,
    parameter int CONFIRM   = 3,
    parameter int DB_CYCLES = 4,
    parameter int TOGGLE    = 1
) (
    input  wire              clk,
    input  wire              rst,
    hvac_sensor_if_if.slave  bus
);

    // Thresholds are compared at TW+1 bits. The exit levels cannot wrap
    // for legal parameter sets.
    localparam logic [TW:0] c_HI      = (TW+1)'(T_HI);
    localparam logic [TW:0] c_LO      = (TW+1)'(T_LO);
    localparam logic [TW:0] c_HI_EXIT = (TW+1)'(T_HI - HYST);
    localparam logic [TW:0] c_LO_EXIT = (TW+1)'(T_LO + HYST);
    localparam logic [3:0]  c_CNT_LAST = 4'(CONFIRM - 1);
    localparam logic [7:0]  c_DB_LAST  = 8'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_NORM = 2'd0,
        ST_HOT  = 2'd1,
        ST_COLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Temperature qualification
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_hot_cnt;
    logic [3:0]  r_cold_cnt;
    logic [3:0]  r_x_cnt;
    logic [3:0]  w_hot_nxt;
    logic [3:0]  w_cold_nxt;
    logic [3:0]  w_x_nxt;
    logic        r_t_cao;
    logic        r_t_thap;

    logic [TW:0] w_temp_x;
    logic        w_is_hot;
    logic        w_is_cold;
    logic        w_exit_hot;
    logic        w_exit_cold;

    assign w_temp_x    = {1'b0, bus.temp};
    assign w_is_hot    = (w_temp_x >  c_HI);
    assign w_is_cold   = (w_temp_x <  c_LO);
    assign w_exit_hot  = (w_temp_x <= c_HI_EXIT);
    assign w_exit_cold = (w_temp_x >= c_LO_EXIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_NORM;
            r_hot_cnt  <= 4'd0;
            r_cold_cnt <= 4'd0;
            r_x_cnt    <= 4'd0;
            r_t_cao    <= 1'b0;
            r_t_thap   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hot_cnt  <= w_hot_nxt;
            r_cold_cnt <= w_cold_nxt;
            r_x_cnt    <= w_x_nxt;
            // The outputs decode the next state. This lets them change on the
            // same edge that accepts the confirming sample.
            r_t_cao    <= (w_state_nxt == ST_HOT);
            r_t_thap   <= (w_state_nxt == ST_COLD);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hot_nxt   = r_hot_cnt;
        w_cold_nxt  = r_cold_cnt;
        w_x_nxt     = r_x_cnt;
        if (bus.temp_valid) begin
            case (r_state)
                ST_NORM: begin
                    if (w_is_hot) begin
                        w_cold_nxt = 4'd0;
                        if (r_hot_cnt == c_CNT_LAST) begin
                            w_state_nxt = ST_HOT;
                            w_hot_nxt   = 4'd0;
                            w_x_nxt     = 4'd0;
                        end else begin
                            w_hot_nxt = r_hot_cnt + 4'd1;
                        end
                    end else if (w_is_cold) begin
                        w_hot_nxt = 4'd0;
                        if (r_cold_cnt == c_CNT_LAST) begin
                            w_state_nxt = ST_COLD;
                            w_cold_nxt  = 4'd0;
                            w_x_nxt     = 4'd0;
                        end else begin
                            w_cold_nxt = r_cold_cnt + 4'd1;
                        end
                    end else begin
                        w_hot_nxt  = 4'd0;
                        w_cold_nxt = 4'd0;
                    end
                end
                // HOT and COLD only ever leave to NORM, so a full swing
                // requalifies from scratch in NORM.
                ST_HOT: begin
                    if (w_exit_hot) begin
                        if (r_x_cnt == c_CNT_LAST) begin
                            w_state_nxt = ST_NORM;
                            w_x_nxt     = 4'd0;
                        end else begin
                            w_x_nxt = r_x_cnt + 4'd1;
                        end
                    end else begin
                        w_x_nxt = 4'd0;
                    end
                end
                ST_COLD: begin
                    if (w_exit_cold) begin
                        if (r_x_cnt == c_CNT_LAST) begin
                            w_state_nxt = ST_NORM;
                            w_x_nxt     = 4'd0;
                        end else begin
                            w_x_nxt = r_x_cnt + 4'd1;
                        end
                    end else begin
                        w_x_nxt = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = ST_NORM;
                    w_hot_nxt   = 4'd0;
                    w_cold_nxt  = 4'd0;
                    w_x_nxt     = 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Button synchronise + debounce
    // ------------------------------------------------------------------------
    logic       r_s1;
    logic       r_s2;
    logic       r_key_db;
    logic [7:0] r_db_cnt;
    logic       r_keypad;
    logic       w_db_fire;

    // s2 has differed from the debounced level for DB_CYCLES edges,
    // counting this one.
    assign w_db_fire = (r_s2 != r_key_db) && (r_db_cnt == c_DB_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_key_db <= 1'b0;
            r_db_cnt <= 8'd0;
        end else begin
            r_s1 <= bus.key_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_key_db) begin
                r_db_cnt <= 8'd0;
            end else if (w_db_fire) begin
                r_key_db <= r_s2;
                r_db_cnt <= 8'd0;
            end else begin
                r_db_cnt <= r_db_cnt + 8'd1;
            end
        end
    end

    if (TOGGLE != 0) begin : g_toggle
        // Only a debounced press (rising edge of key_db) flips the request.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_keypad <= 1'b0;
            end else begin
                r_keypad <= r_keypad ^ (w_db_fire & r_s2);
            end
        end
    end else begin : g_level
        // Track the value key_db takes at this edge so both stay aligned.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_keypad <= 1'b0;
            end else begin
                r_keypad <= w_db_fire ? r_s2 : r_key_db;
            end
        end
    end

    assign bus.t_cao  = r_t_cao;
    assign bus.t_thap = r_t_thap;
    assign bus.keypad = r_keypad;

endmodule
`default_nettype wire
